// File: rtl/ctrl_pkg.sv
// Shared widths, forwarding-select codes and control-bundle types for the
// ctrl_pipe pipeline control slice.
package ctrl_pkg;

  localparam int REG_AW    = 5;
  localparam int ALUCTRL_W = 3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                 memtoreg;
    logic                 memwrite;
    logic                 branch;
    logic                 alusrc;
    logic                 regdst;
    logic                 regwrite;
    logic [ALUCTRL_W-1:0] aluctrl;
  } ctrl_t;

  // Only the fields still consumed downstream travel past EX.
  typedef struct packed {
    logic memtoreg;
    logic memwrite;
    logic regwrite;
  } mem_ctrl_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  // MEM result is younger than WB result, so it wins; $0 is never a source.
  function automatic logic [1:0] fwd_sel(
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_wr,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_wr,
    input logic [REG_AW-1:0] src
  );
    if (mem_we && (mem_wr != '0) && (mem_wr == src))
      return FWD_MEM;
    else if (wb_we && (wb_wr != '0) && (wb_wr == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// Combinational hazard resolution: load-use stall, branch flush/redirect and
// EX operand forwarding selects.
module hazard_unit
  import ctrl_pkg::*;
#(
  parameter int REG_AW = ctrl_pkg::REG_AW
) (
  input  logic              i_ex_memtoreg,
  input  logic              i_ex_regwrite,
  input  logic              i_ex_branch,
  input  logic              i_ex_zero,
  input  logic [REG_AW-1:0] i_ex_writereg,
  input  logic [REG_AW-1:0] i_ex_rs,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_mem_regwrite,
  input  logic [REG_AW-1:0] i_mem_writereg,
  input  logic              i_wb_regwrite,
  input  logic [REG_AW-1:0] i_wb_writereg,
  output logic              o_stall,
  output logic              o_flush,
  output logic              o_pc_src,
  output logic [1:0]        o_forward_a,
  output logic [1:0]        o_forward_b
);

  logic w_taken;
  logic w_load_use;

  assign w_taken    = i_ex_branch & i_ex_zero;
  assign w_load_use = i_ex_memtoreg & i_ex_regwrite & (i_ex_writereg != '0) &
                      ((i_ex_writereg == i_id_rs) | (i_ex_writereg == i_id_rt));

  // A taken branch makes the ID instruction wrong-path, so it never stalls.
  assign o_flush  = w_taken;
  assign o_pc_src = w_taken;
  assign o_stall  = w_load_use & ~w_taken;

  assign o_forward_a = fwd_sel(i_mem_regwrite, i_mem_writereg,
                               i_wb_regwrite, i_wb_writereg, i_ex_rs);
  assign o_forward_b = fwd_sel(i_mem_regwrite, i_mem_writereg,
                               i_wb_regwrite, i_wb_writereg, i_ex_rt);

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers of the 5-stage MIPS pipeline,
// with hazard resolution delegated to hazard_unit.
module ctrl_pipe #(
  parameter int REG_AW    = ctrl_pkg::REG_AW,
  parameter int ALUCTRL_W = ctrl_pkg::ALUCTRL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_memtoreg,
  input  logic                 id_memwrite,
  input  logic                 id_branch,
  input  logic                 id_alusrc,
  input  logic                 id_regdst,
  input  logic                 id_regwrite,
  input  logic [ALUCTRL_W-1:0] id_aluctrl,
  input  logic [REG_AW-1:0]    id_rs,
  input  logic [REG_AW-1:0]    id_rt,
  input  logic [REG_AW-1:0]    id_rd,
  input  logic                 ex_zero,
  output logic                 ex_alusrc,
  output logic                 ex_regdst,
  output logic [ALUCTRL_W-1:0] ex_aluctrl,
  output logic [1:0]           forward_a,
  output logic [1:0]           forward_b,
  output logic                 mem_memwrite,
  output logic [REG_AW-1:0]    mem_writereg,
  output logic [REG_AW-1:0]    wb_writereg,
  output logic                 wb_memtoreg,
  output logic                 wb_regwrite,
  output logic                 stall,
  output logic                 flush,
  output logic                 pc_src
);

  import ctrl_pkg::*;

  ctrl_t             w_id_ctrl;
  ctrl_t             r_ex_ctrl;
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic [REG_AW-1:0] r_ex_rd;
  logic [REG_AW-1:0] w_ex_writereg;
  mem_ctrl_t         r_mem_ctrl;
  logic [REG_AW-1:0] r_mem_writereg;
  wb_ctrl_t          r_wb_ctrl;
  logic [REG_AW-1:0] r_wb_writereg;
  logic              w_stall;
  logic              w_flush;
  logic              w_pc_src;

  assign w_id_ctrl = '{memtoreg: id_memtoreg, memwrite: id_memwrite,
                       branch:   id_branch,   alusrc:   id_alusrc,
                       regdst:   id_regdst,   regwrite: id_regwrite,
                       aluctrl:  id_aluctrl};

  assign w_ex_writereg = r_ex_ctrl.regdst ? r_ex_rd : r_ex_rt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_ctrl      <= '0;
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_rd        <= '0;
      r_mem_ctrl     <= '0;
      r_mem_writereg <= '0;
      r_wb_ctrl      <= '0;
      r_wb_writereg  <= '0;
    end else begin
      if (w_stall || w_flush) begin
        r_ex_ctrl <= '0;
        r_ex_rs   <= '0;
        r_ex_rt   <= '0;
        r_ex_rd   <= '0;
      end else begin
        r_ex_ctrl <= w_id_ctrl;
        r_ex_rs   <= id_rs;
        r_ex_rt   <= id_rt;
        r_ex_rd   <= id_rd;
      end
      r_mem_ctrl     <= '{memtoreg: r_ex_ctrl.memtoreg,
                          memwrite: r_ex_ctrl.memwrite,
                          regwrite: r_ex_ctrl.regwrite};
      r_mem_writereg <= w_ex_writereg;
      r_wb_ctrl      <= '{memtoreg: r_mem_ctrl.memtoreg,
                          regwrite: r_mem_ctrl.regwrite};
      r_wb_writereg  <= r_mem_writereg;
    end
  end

  hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .i_ex_memtoreg  (r_ex_ctrl.memtoreg),
    .i_ex_regwrite  (r_ex_ctrl.regwrite),
    .i_ex_branch    (r_ex_ctrl.branch),
    .i_ex_zero      (ex_zero),
    .i_ex_writereg  (w_ex_writereg),
    .i_ex_rs        (r_ex_rs),
    .i_ex_rt        (r_ex_rt),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_mem_regwrite (r_mem_ctrl.regwrite),
    .i_mem_writereg (r_mem_writereg),
    .i_wb_regwrite  (r_wb_ctrl.regwrite),
    .i_wb_writereg  (r_wb_writereg),
    .o_stall        (w_stall),
    .o_flush        (w_flush),
    .o_pc_src       (w_pc_src),
    .o_forward_a    (forward_a),
    .o_forward_b    (forward_b)
  );

  assign ex_alusrc    = r_ex_ctrl.alusrc;
  assign ex_regdst    = r_ex_ctrl.regdst;
  assign ex_aluctrl   = r_ex_ctrl.aluctrl;
  assign mem_memwrite = r_mem_ctrl.memwrite;
  assign mem_writereg = r_mem_writereg;
  assign wb_writereg  = r_wb_writereg;
  assign wb_memtoreg  = r_wb_ctrl.memtoreg;
  assign wb_regwrite  = r_wb_ctrl.regwrite;
  assign stall        = w_stall;
  assign flush        = w_flush;
  assign pc_src       = w_pc_src;

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Receiving end of the control-unit bundle (MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, ALUCtrl).
- Carries decoded ID-stage control through the ID/EX, EX/MEM and MEM/WB registers of the 5-stage MIPS pipeline, alongside register addresses.
- Also resolves load-use stalls, taken-branch flushes and EX operand forwarding selects, and hands per-stage control to datapath muxes, ALU, data memory and register file.

Parameters:
- REG_AW, 5, register-address width.
- ALUCTRL_W, 3, ALU control width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_memtoreg, id_memwrite, id_branch, id_alusrc, id_regdst, id_regwrite  in  1 each  decoded control for the instruction in ID.
- id_aluctrl  in  ALUCTRL_W  decoded ALU control.
- id_rs, id_rt, id_rd  in  REG_AW each  register fields of the ID instruction.
- ex_zero  in  1  ALU zero flag of the EX instruction.
- ex_alusrc, ex_regdst  out  1 each  EX datapath mux selects.
- ex_aluctrl  out  ALUCTRL_W  to ALU.
- forward_a, forward_b  out  2 each  EX operand selects: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- mem_memwrite  out  1  data-memory write enable.
- mem_writereg, wb_writereg  out  REG_AW each  destination register in MEM and WB.
- wb_memtoreg, wb_regwrite  out  1 each  writeback select and regfile write enable.
- stall  out  1  hold PC and IF/ID.
- flush  out  1  clear IF/ID.
- pc_src  out  1  select branch target.

Behaviour:
- One clock domain. Reset is synchronous, active-low: on a rising edge with rst_n=0, every stage register (all control bits, ALU control, rs/rt/writereg fields) clears to 0. Inputs are ignored that cycle. Reset mid-operation discards all in-flight instructions.
- Consequences of reset: all outputs are 0 from the following cycle; stall, flush and pc_src are 0 because they derive only from cleared registers.
- Write-register select, resolved in EX: ex_writereg = ex_regdst ? ex_rd : ex_rt.
- Each rising edge, the EX/MEM register loads EX state and MEM/WB loads MEM state unconditionally.
- Each rising edge, ID/EX loads the ID inputs, or a bubble (all control 0, addresses 0) when stall or flush is 1.
- Latency: ID control reaches the EX outputs 1 cycle later, MEM 2 cycles, WB 3 cycles.
- Branch: pc_src = flush = ex_branch & ex_zero, combinational.
- Load-use hazard:
  - load_use = ex_memtoreg & ex_regwrite & (ex_writereg != 0) & (ex_writereg == id_rs | ex_writereg == id_rt).
  - id_rt is always compared (conservative).
  - stall = load_use & ~flush; flush has priority because the ID instruction is wrong-path.
- Forwarding, rs (forward_a):
  - 10 if mem_regwrite & mem_writereg != 0 & mem_writereg == ex_rs;
  - else 01 if wb_regwrite & wb_writereg != 0 & wb_writereg == ex_rs;
  - else 00.
  - MEM has priority over WB.
- Forwarding, rt (forward_b): identical rule using ex_rt.
- Register $0 never forwards and never stalls.
- A bubble is indistinguishable from a nop: no writes and no forwarding source.
- Simultaneous load-use and taken branch: flush=1, stall=0, ID/EX bubbles, PC redirects.
- Consecutive stalls: each cycle stall is asserted, another bubble enters ID/EX. Upstream holds, so the ID inputs stay stable until load_use clears; this takes one cycle in practice.
- No combinational path from the id_* control inputs to any output except stall, which has id_rs/id_rt in its path.

Decomposition:
- Shared package ctrl_pkg holds:
  - REG_AW and ALUCTRL_W;
  - forwarding-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10;
  - a packed control-bundle typedef ctrl_t (memtoreg, memwrite, branch, alusrc, regdst, regwrite, aluctrl), so stage registers and bubbles are single assignments.
- One natural sub-module: hazard_unit, holding the combinational load_use/stall/flush/pc_src/forward_a/forward_b logic. Stage registers stay in ctrl_pipe.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all id_* inputs =1 -> every output 0 the cycle after; release -> the first instruction appears on the EX outputs 1 cycle later.
- Pass-through: R-type (regdst=1, regwrite=1, aluctrl=010, rd=3), then lw (memtoreg=1, alusrc=1, rt=4) -> ex_regdst=1 at t+1, mem_writereg=3 at t+2, wb_regwrite=1 and wb_writereg=3 at t+3; lw follows one cycle behind with wb_memtoreg=1, wb_writereg=4.
- Load-use: lw $2, then add with rs=2 -> stall=1 for exactly one cycle; EX shows a bubble (all control 0); next cycle forward_a=01.
- Forwarding priority: add $5, add $5, then add using rs=5 and rt=5 -> forward_a=forward_b=10 (MEM beats WB). The same sequence with writes to $0 -> both selects 00.
- Taken branch: beq in EX with ex_zero=1 -> pc_src=flush=1 that cycle, ID/EX bubbled next edge. With ex_zero=0 -> pc_src=0 and no bubble.
- Branch plus load-use: load_use condition true in the same cycle as a taken branch -> flush=1, stall=0. Mid-stream rst_n=0 -> all stages 0 on the next edge.
